// File: rtl/eth_pkg.sv
// ============================================================================
// Module      : eth_pkg
// Description : Shared types for the Ethernet transmit path (beat, arbiter FSM)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eth_pkg;

    localparam int ETH_DATA_W = 32;
    localparam int ETH_MOD_W  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ETH_DATA_W-1:0] data;
        logic [ETH_MOD_W-1:0]  mod;
        logic                  sop;
        logic                  eop;
    } eth_beat_t;

endpackage

`default_nettype wire

// File: rtl/eth_st_skid.sv
// ============================================================================
// Module      : eth_st_skid
// Description : Output register plus one skid entry; breaks the ready path
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_st_skid
    import eth_pkg::*;
#(
    parameter type T = eth_beat_t
) (
    input  logic clk,
    input  logic reset,
    input  T     i_in_beat,
    input  logic i_in_vld,
    output logic o_in_rdy,
    output T     o_out_beat,
    output logic o_out_vld,
    input  logic i_out_rdy
);

    T     r_out_beat;
    logic r_out_vld;
    T     r_skid_beat;
    logic r_skid_vld;

    logic w_out_load;
    logic w_in_acc;

    // Ready depends only on a register, so the downstream ready never reaches the sources.
    assign o_in_rdy   = ~r_skid_vld;
    assign w_in_acc   = i_in_vld & ~r_skid_vld;
    assign w_out_load = ~r_out_vld | i_out_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_beat  <= T'('0);
            r_out_vld   <= 1'b0;
            r_skid_beat <= T'('0);
            r_skid_vld  <= 1'b0;
        end else if (w_out_load) begin
            if (r_skid_vld) begin
                r_out_beat <= r_skid_beat;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= w_in_acc;
                if (w_in_acc) begin
                    r_out_beat <= i_in_beat;
                end
            end
        end else if (w_in_acc) begin
            r_skid_beat <= i_in_beat;
            r_skid_vld  <= 1'b1;
        end
    end

    assign o_out_beat = r_out_beat;
    assign o_out_vld  = r_out_vld;

endmodule

`default_nettype wire

// File: rtl/eth_tx_arb.sv
// ============================================================================
// Module      : eth_tx_arb
// Description : Packet-granular round-robin arbiter of two sources onto MAC ff_tx
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int DATA_W = ETH_DATA_W,
    parameter int MOD_W  = ETH_MOD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic [MOD_W-1:0]  i_a_mod,
    input  logic              i_a_sop,
    input  logic              i_a_eop,
    input  logic              i_a_vld,
    output logic              o_a_rdy,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic [MOD_W-1:0]  i_b_mod,
    input  logic              i_b_sop,
    input  logic              i_b_eop,
    input  logic              i_b_vld,
    output logic              o_b_rdy,
    output logic [DATA_W-1:0] o_tx_data,
    output logic [MOD_W-1:0]  o_tx_mod,
    output logic              o_tx_sop,
    output logic              o_tx_eop,
    output logic              o_tx_vld,
    input  logic              i_tx_rdy,
    output logic [CNT_W-1:0]  o_pkt_cnt_a,
    output logic [CNT_W-1:0]  o_pkt_cnt_b,
    output logic              o_err_a,
    output logic              o_err_b
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [MOD_W-1:0]  mod;
        logic              sop;
        logic              eop;
    } beat_t;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last_b;
    logic             r_beat_seen;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic             r_err_a;
    logic             r_err_b;

    logic  w_a_rdy;
    logic  w_b_rdy;
    logic  w_err_a;
    logic  w_err_b;
    logic  w_cand_a;
    logic  w_cand_b;
    logic  w_fwd_a;
    logic  w_fwd_b;
    logic  w_in_vld;
    beat_t w_in_beat;
    logic  w_skid_rdy;
    beat_t w_out_beat;

    always_comb begin
        w_state_nxt = r_state;
        w_a_rdy     = 1'b0;
        w_b_rdy     = 1'b0;
        w_err_a     = 1'b0;
        w_err_b     = 1'b0;
        w_fwd_a     = 1'b0;
        w_fwd_b     = 1'b0;
        w_in_vld    = 1'b0;
        w_in_beat   = '{data: i_a_data, mod: i_a_mod, sop: i_a_sop, eop: i_a_eop};
        w_cand_a    = i_a_vld & i_a_sop;
        w_cand_b    = i_b_vld & i_b_sop;

        case (r_state)
            IDLE: begin
                // A valid beat with no sop cannot start a packet: swallow it and flag it.
                if (i_a_vld && !i_a_sop) begin
                    w_a_rdy = 1'b1;
                    w_err_a = 1'b1;
                end
                if (i_b_vld && !i_b_sop) begin
                    w_b_rdy = 1'b1;
                    w_err_b = 1'b1;
                end
                if (w_cand_a && w_cand_b) begin
                    w_state_nxt = r_last_b ? GRANT_A : GRANT_B;
                end else if (w_cand_a) begin
                    w_state_nxt = GRANT_A;
                end else if (w_cand_b) begin
                    w_state_nxt = GRANT_B;
                end
            end
            GRANT_A: begin
                w_a_rdy  = w_skid_rdy;
                w_in_vld = i_a_vld;
                w_fwd_a  = i_a_vld & w_skid_rdy;
                if (w_fwd_a) begin
                    w_err_a = i_a_sop & r_beat_seen;
                    if (i_a_eop) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GRANT_B: begin
                w_b_rdy   = w_skid_rdy;
                w_in_vld  = i_b_vld;
                w_in_beat = '{data: i_b_data, mod: i_b_mod, sop: i_b_sop, eop: i_b_eop};
                w_fwd_b   = i_b_vld & w_skid_rdy;
                if (w_fwd_b) begin
                    w_err_b = i_b_sop & r_beat_seen;
                    if (i_b_eop) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Nothing is handed over while reset is held.
        if (reset) begin
            w_a_rdy = 1'b0;
            w_b_rdy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last_b    <= 1'b1;
            r_beat_seen <= 1'b0;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
            r_err_a     <= 1'b0;
            r_err_b     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_err_a     <= w_err_a;
            r_err_b     <= w_err_b;
            r_beat_seen <= (r_state != IDLE) & (r_beat_seen | w_fwd_a | w_fwd_b);
            if (w_fwd_a && i_a_eop) begin
                r_last_b <= 1'b0;
                r_cnt_a  <= r_cnt_a + CNT_W'(1);
            end
            if (w_fwd_b && i_b_eop) begin
                r_last_b <= 1'b1;
                r_cnt_b  <= r_cnt_b + CNT_W'(1);
            end
        end
    end

    eth_st_skid #(
        .T (beat_t)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .i_in_beat  (w_in_beat),
        .i_in_vld   (w_in_vld),
        .o_in_rdy   (w_skid_rdy),
        .o_out_beat (w_out_beat),
        .o_out_vld  (o_tx_vld),
        .i_out_rdy  (i_tx_rdy)
    );

    assign o_a_rdy     = w_a_rdy;
    assign o_b_rdy     = w_b_rdy;
    assign o_tx_data   = w_out_beat.data;
    assign o_tx_mod    = w_out_beat.mod;
    assign o_tx_sop    = w_out_beat.sop;
    assign o_tx_eop    = w_out_beat.eop;
    assign o_pkt_cnt_a = r_cnt_a;
    assign o_pkt_cnt_b = r_cnt_b;
    assign o_err_a     = r_err_a;
    assign o_err_b     = r_err_b;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
// ============================================================================
// Module      : tb_eth_tx_arb
// Description : Self-checking bench for eth_tx_arb against a packet-level model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_tx_arb;

    localparam int DW = 32;
    localparam int MW = 2;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [MW-1:0] mod;
        logic          sop;
        logic          eop;
    } mbeat_t;

    logic          clk;
    logic          reset;
    logic [DW-1:0] a_data, b_data;
    logic [MW-1:0] a_mod, b_mod;
    logic          a_sop, a_eop, a_vld, a_rdy;
    logic          b_sop, b_eop, b_vld, b_rdy;
    logic [DW-1:0] tx_data;
    logic [MW-1:0] tx_mod;
    logic          tx_sop, tx_eop, tx_vld, tx_rdy;
    logic [CW-1:0] cnt_a, cnt_b;
    logic          err_a, err_b;

    eth_tx_arb #(.DATA_W(DW), .MOD_W(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .i_a_data(a_data), .i_a_mod(a_mod), .i_a_sop(a_sop), .i_a_eop(a_eop),
        .i_a_vld(a_vld), .o_a_rdy(a_rdy),
        .i_b_data(b_data), .i_b_mod(b_mod), .i_b_sop(b_sop), .i_b_eop(b_eop),
        .i_b_vld(b_vld), .o_b_rdy(b_rdy),
        .o_tx_data(tx_data), .o_tx_mod(tx_mod), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
        .o_tx_vld(tx_vld), .i_tx_rdy(tx_rdy),
        .o_pkt_cnt_a(cnt_a), .o_pkt_cnt_b(cnt_b), .o_err_a(err_a), .o_err_b(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level model: in-flight beats, packet owner, round-robin memory, counters.
    mbeat_t        inflight[$];
    mbeat_t        delivered[$];
    int            owner;
    bit            last_a;
    bit            first_seen;
    bit            started;
    logic [CW-1:0] m_cnt_a, m_cnt_b;
    bit            m_err_a, m_err_b;
    int            err_a_pulses;
    bit            rnd_mode;

    always @(negedge clk) begin
        int  sz;
        bit  na, nb, ca, cb;
        sz = inflight.size();
        if (reset) begin
            check("rdy_a_reset", a_rdy, 1'b0);
            check("rdy_b_reset", b_rdy, 1'b0);
            inflight.delete();
            owner = 0; last_a = 0; first_seen = 0;
            m_cnt_a = '0; m_cnt_b = '0; m_err_a = 0; m_err_b = 0;
            started = 1;
        end else if (started) begin
            check("tx_vld", tx_vld, sz > 0);
            if (tx_vld && sz > 0)
                check("tx_beat", {tx_data, tx_mod, tx_sop, tx_eop}, inflight[0]);
            check("cnt_a", cnt_a, m_cnt_a);
            check("cnt_b", cnt_b, m_cnt_b);
            check("err_a", err_a, m_err_a);
            check("err_b", err_b, m_err_b);
            if (err_a) err_a_pulses++;
            case (owner)
                0: begin
                    check("rdy_a", a_rdy, a_vld & ~a_sop);
                    check("rdy_b", b_rdy, b_vld & ~b_sop);
                end
                1: begin
                    check("rdy_a", a_rdy, sz < 2);
                    check("rdy_b", b_rdy, 1'b0);
                end
                default: begin
                    check("rdy_a", a_rdy, 1'b0);
                    check("rdy_b", b_rdy, sz < 2);
                end
            endcase

            // Advance the model across the coming rising edge.
            na = 0; nb = 0;
            if (tx_vld && tx_rdy && sz > 0) delivered.push_back(inflight.pop_front());
            case (owner)
                0: begin
                    na = a_vld & ~a_sop;
                    nb = b_vld & ~b_sop;
                    ca = a_vld & a_sop;
                    cb = b_vld & b_sop;
                    if (ca && cb) owner = last_a ? 2 : 1;
                    else if (ca) owner = 1;
                    else if (cb) owner = 2;
                    first_seen = 0;
                end
                1: if (a_vld && sz < 2) begin
                    inflight.push_back({a_data, a_mod, a_sop, a_eop});
                    na = a_sop & first_seen;
                    first_seen = 1;
                    if (a_eop) begin m_cnt_a++; last_a = 1; owner = 0; end
                end
                default: if (b_vld && sz < 2) begin
                    inflight.push_back({b_data, b_mod, b_sop, b_eop});
                    nb = b_sop & first_seen;
                    first_seen = 1;
                    if (b_eop) begin m_cnt_b++; last_a = 0; owner = 0; end
                end
            endcase
            m_err_a = na;
            m_err_b = nb;
        end
    end

    initial begin
        tx_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_beat(input bit src_b, input logic [DW-1:0] d, input logic [MW-1:0] m,
                             input bit s, input bit e);
        bit acc;
        if (src_b) begin b_data = d; b_mod = m; b_sop = s; b_eop = e; b_vld = 1'b1; end
        else       begin a_data = d; a_mod = m; a_sop = s; a_eop = e; a_vld = 1'b1; end
        acc = 0;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = src_b ? b_rdy : a_rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_tests++; n_fail++;
            $display("FAIL handshake_timeout: src_b=%0d got no rdy required rdy", src_b);
        end
        if (src_b) b_vld = 1'b0; else a_vld = 1'b0;
    endtask

    task automatic send_pkt(input bit src_b, input logic [DW-1:0] base, input logic [DW-1:0] step,
                            input int n, input logic [MW-1:0] m);
        for (int i = 0; i < n; i++)
            send_beat(src_b, base + step * i, (i == n - 1) ? m : '0, i == 0, i == n - 1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(posedge clk);
            #2;
            done = (inflight.size() == 0) && (owner == 0) && !tx_vld;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: got inflight=%0d required 0", inflight.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rnd_mode = 0;
        a_data = '0; a_mod = '0; a_sop = 0; a_eop = 0; a_vld = 0;
        b_data = '0; b_mod = '0; b_sop = 0; b_eop = 0; b_vld = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("reset_cnt_a", cnt_a, 0);
        check("reset_tx_vld", tx_vld, 0);

        // 4-beat packet from A
        delivered.delete();
        send_pkt(0, 32'h11, 32'h11, 4, 2'd2);
        wait_drain();
        check("t1_count", delivered.size(), 4);
        check("t1_first", delivered[0], {32'h11, 2'd0, 1'b1, 1'b0});
        check("t1_last", delivered[3], {32'h44, 2'd2, 1'b0, 1'b1});
        check("t1_cnt_a", cnt_a, 1);

        // Tie right after reset: A wins
        do_reset();
        delivered.delete();
        fork
            send_pkt(0, 32'hA0, 1, 3, 2'd1);
            send_pkt(1, 32'hB0, 1, 2, 2'd3);
        join
        wait_drain();
        check("tie1_first", delivered[0].data, 32'hA0);
        check("tie1_second_pkt", delivered[3].data, 32'hB0);

        // A served last, so the next tie goes to B
        send_pkt(0, 32'hC0, 1, 2, 2'd0);
        wait_drain();
        delivered.delete();
        fork
            send_pkt(0, 32'hE0, 1, 2, 2'd0);
            send_pkt(1, 32'hD0, 1, 1, 2'd1);
        join
        wait_drain();
        check("tie2_first", delivered[0].data, 32'hD0);
        check("tie2_second_pkt", delivered[1].data, 32'hE0);

        // 16-beat B packet with a stuttering MAC
        delivered.delete();
        rnd_mode = 1;
        send_pkt(1, 32'h100, 1, 16, 2'd0);
        wait_drain();
        rnd_mode = 0;
        @(posedge clk);
        #2;
        check("stall_count", delivered.size(), 16);
        check("stall_last", delivered[15], {32'h10F, 2'd0, 1'b0, 1'b1});

        // Orphan beat in IDLE is dropped
        delivered.delete();
        err_a_pulses = 0;
        a_data = 32'h55; a_mod = '0; a_sop = 0; a_eop = 0; a_vld = 1;
        @(posedge clk);
        #1;
        a_vld = 0;
        repeat (3) @(posedge clk);
        #2;
        check("drop_err_pulses", err_a_pulses, 1);
        check("drop_no_output", delivered.size(), 0);

        // Reset on beat 3 of an 8-beat A packet
        send_beat(0, 32'h300, 2'd0, 1, 0);
        send_beat(0, 32'h301, 2'd0, 0, 0);
        a_data = 32'h302; a_sop = 0; a_eop = 0; a_vld = 1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        a_vld = 0;
        #2;
        check("rst_mid_tx_vld", tx_vld, 0);
        check("rst_mid_cnt_a", cnt_a, 0);
        check("rst_mid_cnt_b", cnt_b, 0);
        send_pkt(1, 32'h400, 1, 2, 2'd1);
        wait_drain();
        check("rst_mid_b_cnt", cnt_b, 1);

        // Counter wrap with single-beat packets
        for (int i = 0; i < 255; i++) send_pkt(0, i, 1, 1, 2'd0);
        wait_drain();
        check("wrap_before", cnt_a, 255);
        send_pkt(0, 32'hFF, 1, 1, 2'd0);
        wait_drain();
        check("wrap_after", cnt_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
